if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipeline CPU. Sits directly upstream of the next-PC logic: it owns the PC register, feeds PC to the next-PC logic and consumes its NPC result.
- Issues requests to instruction memory over a req/ack handshake whose latency can vary.
- Loads the IF/ID pipeline register.
- Handles downstream stalls with a one-entry hold buffer, and handles branch/jump redirects, including discarding a fetch that is still in flight when a redirect arrives.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INST, 32'h0000_0013, instruction word loaded into inst_ID on reset and on flush (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- npc  input  32  next PC from the next-PC logic (PC+4 or redirect target).
- pc_write  input  1  hazard unit: PC may advance.
- ifid_write  input  1  hazard unit: IF/ID may load; 0 means decode is stalled.
- redirect  input  1  EX resolved a taken branch/jump/jalr; npc holds the target.
- PC  output  32  current fetch PC, sent to the next-PC logic.
- imem_req  output  1  instruction memory request.
- imem_addr  output  32  request address.
- imem_ack  input  1  single-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  fetched instruction word.
- PC_ID  output  32  IF/ID register: PC of the instruction.
- inst_ID  output  32  IF/ID register: instruction word.
- valid_ID  output  1  IF/ID register: entry is a real instruction.
- if_stall  output  1  fetch is waiting on memory (input to the hazard unit).

Behaviour:
- Reset (rst=1 at an edge):
  - PC=RESET_PC, state=S_FETCH, hold buffer empty.
  - PC_ID=0, inst_ID=NOP_INST, valid_ID=0.
  - imem_req is forced to 0 while rst=1.
- States: S_FETCH, S_HOLD, S_DROP.
- Handshake rules:
  - imem_req=1 in S_FETCH and S_DROP; 0 in S_HOLD.
  - Once raised, imem_req and imem_addr stay constant until imem_ack.
  - imem_ack may arrive in the same cycle as the request (zero wait), which gives 1-cycle fetch-to-IF/ID latency.
  - imem_addr=PC in S_FETCH; imem_addr=drop_addr (latched) in S_DROP.
- if_stall = imem_req & ~imem_ack.
- Delivery: instruction X with address A is written to IF/ID as PC_ID<=A, inst_ID<=X, valid_ID<=1.
- PC advances (PC<=npc) only on a delivery with pc_write=1.
  - Delivery with pc_write=0 leaves PC unchanged, so the same PC is refetched.
- Bubble: if ifid_write=1 and nothing is delivered this cycle, valid_ID<=0; inst_ID and PC_ID keep their values.
- ifid_write=0 and no redirect: the IF/ID register holds.
- S_FETCH:
  - ack & ifid_write: deliver (PC, rdata); stay in S_FETCH.
  - ack & ~ifid_write: hold_inst<=rdata, hold_pc<=PC; go to S_HOLD. PC is not advanced.
  - no ack: stay.
- S_HOLD:
  - ifid_write: deliver (hold_pc, hold_inst); advance PC if pc_write; go to S_FETCH.
  - else: stay.
- S_DROP:
  - ack: discard rdata; go to S_FETCH. The IF/ID register follows the bubble rule.
  - else: stay.
- Redirect has top priority in every state and overrides ifid_write and pc_write:
  - PC<=npc, valid_ID<=0, inst_ID<=NOP_INST, and any hold buffer is discarded.
  - S_FETCH with no ack in the same cycle: drop_addr<=PC; go to S_DROP.
  - S_FETCH with ack in the same cycle: discard the response; stay in S_FETCH, so the new target is requested next cycle.
  - S_HOLD: go to S_FETCH.
  - S_DROP without ack: stay in S_DROP; drop_addr is unchanged.
  - S_DROP with ack: go to S_FETCH.
- rst asserted mid-request: the state is abandoned. The memory side is reset on the same reset, so no stale ack is expected.
- Arithmetic: none internally. PC wrap-around is whatever npc supplies; the block stores npc verbatim.

Test Plan:
- Reset then zero-wait memory (ack in the same cycle as req), ifid_write=pc_write=1, npc=PC+4 -> PC_ID/inst_ID sequence 0x0, 0x4, 0x8 on consecutive cycles, valid_ID=1 continuously.
- 2-cycle-latency memory -> if_stall=1 for exactly one cycle per fetch; valid_ID alternates 1/0; imem_addr stable while req is high.
- ack arrives while ifid_write=0 for 3 cycles -> state S_HOLD, imem_req=0, IF/ID unchanged; ifid_write=1 delivers the held word with its own PC, then fetching resumes at npc.
- redirect with npc=0x100 while a fetch of 0x8 is outstanding (ack 2 cycles later) -> IF/ID flushed to NOP_INST with valid_ID=0; imem_addr stays 0x8 until ack; that data is discarded; next request is 0x100.
- redirect and ack in the same cycle with ifid_write=1 -> no delivery, inst_ID=NOP_INST, next imem_addr=target.
- load-use stall (pc_write=ifid_write=0) for 2 cycles with zero-wait memory -> PC, PC_ID and inst_ID held; the word fetched at the first stalled ack is delivered exactly once after the stall.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake to
// instruction memory, and loads the IF/ID pipeline register. A one-entry
// hold buffer absorbs a response that arrives while decode is stalled, and
// a drop state swallows a response that was in flight when EX redirected.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        pc_write,
    input  logic        ifid_write,
    input  logic        redirect,
    output logic [31:0] PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_ID,
    output logic [31:0] inst_ID,
    output logic        valid_ID,
    output logic        if_stall
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    logic [31:0] drop_addr;

    // Request side: the hold state blocks new requests, the drop state keeps
    // presenting the abandoned address until its response comes back.
    always_comb begin
        imem_req  = ~rst && (state != S_HOLD);
        imem_addr = (state == S_DROP) ? drop_addr : PC;
        if_stall  = imem_req & ~imem_ack;
    end

    // Fetch FSM, PC register, hold buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            PC        <= RESET_PC;
            hold_pc   <= '0;
            hold_inst <= '0;
            drop_addr <= '0;
            PC_ID     <= '0;
            inst_ID   <= NOP_INST;
            valid_ID  <= 1'b0;
        end else if (redirect) begin
            // Redirect beats stalls: flush IF/ID, take the target, and make
            // sure any response still owed by memory is thrown away.
            PC       <= npc;
            valid_ID <= 1'b0;
            inst_ID  <= NOP_INST;
            case (state)
                S_FETCH: begin
                    if (!imem_ack) begin
                        drop_addr <= PC;
                        state     <= S_DROP;
                    end
                end
                S_HOLD: state <= S_FETCH;
                S_DROP: begin
                    if (imem_ack) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        if (ifid_write) begin
                            PC_ID    <= PC;
                            inst_ID  <= imem_rdata;
                            valid_ID <= 1'b1;
                            if (pc_write) begin
                                PC <= npc;
                            end
                        end else begin
                            // PC stays put so the held word keeps matching PC
                            // when it is finally delivered.
                            hold_pc   <= PC;
                            hold_inst <= imem_rdata;
                            state     <= S_HOLD;
                        end
                    end else if (ifid_write) begin
                        valid_ID <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (ifid_write) begin
                        PC_ID    <= hold_pc;
                        inst_ID  <= hold_inst;
                        valid_ID <= 1'b1;
                        if (pc_write) begin
                            PC <= npc;
                        end
                        state <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (ifid_write) begin
                        valid_ID <= 1'b0;
                    end
                    if (imem_ack) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a variable-latency memory model drives the
// handshake, and a transaction-level model (pending-response queue plus a
// "discard next response" flag) predicts PC, IF/ID and the request side.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc;
    logic        pc_write;
    logic        ifid_write;
    logic        redirect;
    logic [31:0] PC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC_ID;
    logic [31:0] inst_ID;
    logic        valid_ID;
    logic        if_stall;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .RESET_PC(RST_PC),
        .NOP_INST(NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .npc       (npc),
        .pc_write  (pc_write),
        .ifid_write(ifid_write),
        .redirect  (redirect),
        .PC        (PC),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .PC_ID     (PC_ID),
        .inst_ID   (inst_ID),
        .valid_ID  (valid_ID),
        .if_stall  (if_stall)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_t;

    // reference model
    fetch_t      held[$];
    logic [31:0] m_pc;
    logic [31:0] m_pc_id;
    logic [31:0] m_inst;
    logic        m_valid;
    logic        m_discard;
    logic [31:0] m_drop;

    // memory model
    int lat_cfg  = 0;
    int lat      = 0;
    int wait_cnt = 0;

    // per-cycle observations and predictions
    logic        obs_req;
    logic        obs_stall;
    logic [31:0] obs_addr;
    logic        exp_req;
    logic        exp_stall;
    logic [31:0] exp_addr;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
    endfunction

    function automatic int pick_lat();
        return (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
    endfunction

    // One clock: drive inputs, let memory answer, sample, clock, update model.
    task automatic cycle(input logic r, input logic redir, input logic [31:0] target,
                         input logic pw, input logic iw);
        logic        resp;
        logic [31:0] rd;
        fetch_t      f;
        rst        = r;
        redirect   = redir;
        pc_write   = pw;
        ifid_write = iw;
        npc        = redir ? target : m_pc + 32'd4;
        #1;
        imem_ack   = imem_req && (wait_cnt >= lat);
        imem_rdata = memword(imem_addr);
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_stall = if_stall;
        exp_req   = !r && (held.size() == 0);
        exp_addr  = m_discard ? m_drop : m_pc;
        exp_stall = exp_req && !imem_ack;
        resp      = exp_req && imem_ack;
        rd        = memword(exp_addr);
        @(posedge clk);
        if (r) begin
            m_pc = RST_PC; held.delete(); m_discard = 1'b0;
            m_pc_id = '0; m_inst = NOP; m_valid = 1'b0;
        end else if (redir) begin
            if (resp) m_discard = 1'b0;
            else if (exp_req && !m_discard) begin
                m_discard = 1'b1;
                m_drop    = m_pc;
            end
            m_pc = npc; m_valid = 1'b0; m_inst = NOP; held.delete();
        end else if (held.size() != 0) begin
            if (iw) begin
                f = held.pop_front();
                m_pc_id = f.addr; m_inst = f.data; m_valid = 1'b1;
                if (pw) m_pc = npc;
            end
        end else if (resp && m_discard) begin
            m_discard = 1'b0;
            if (iw) m_valid = 1'b0;
        end else if (resp) begin
            if (iw) begin
                m_pc_id = exp_addr; m_inst = rd; m_valid = 1'b1;
                if (pw) m_pc = npc;
            end else begin
                f.addr = exp_addr; f.data = rd;
                held.push_back(f);
            end
        end else if (iw) begin
            m_valid = 1'b0;
        end
        if (r) begin
            wait_cnt = 0; lat = pick_lat();
        end else if (obs_req) begin
            if (imem_ack) begin
                wait_cnt = 0; lat = pick_lat();
            end else begin
                wait_cnt++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        lat_cfg = 0;
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (obs_req !== 1'b0) begin
            errors++; $display("FAIL reset_req got=%b want=0", obs_req);
        end
        checks++;
        if ({PC, PC_ID, inst_ID, valid_ID} !== {RST_PC, 32'h0, NOP, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got PC=%h PC_ID=%h inst=%h v=%b want %h 0 %h 0",
                     PC, PC_ID, inst_ID, valid_ID, RST_PC, NOP);
        end
    endtask

    task automatic test_zero_wait();
        lat_cfg = 0; lat = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
            checks++;
            if ({PC_ID, inst_ID, valid_ID} !== {32'(i * 4), memword(32'(i * 4)), 1'b1}) begin
                errors++;
                $display("FAIL zero_wait_seq i=%0d got PC_ID=%h inst=%h v=%b want %h %h 1",
                         i, PC_ID, inst_ID, valid_ID, 32'(i * 4), memword(32'(i * 4)));
            end
            checks++;
            if (obs_req !== 1'b1 || obs_stall !== 1'b0) begin
                errors++;
                $display("FAIL zero_wait_hs i=%0d got req=%b stall=%b want 1 0", i, obs_req, obs_stall);
            end
        end
    endtask

    task automatic test_two_cycle();
        int          stalls;
        logic [31:0] prev_addr;
        stalls = 0; prev_addr = '0;
        lat_cfg = 1; lat = 1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
            if (obs_stall) stalls++;
            checks++;
            if (i % 2 == 1 && obs_addr !== prev_addr) begin
                errors++; $display("FAIL two_cycle_addr_stable got=%h want=%h", obs_addr, prev_addr);
            end
            prev_addr = obs_addr;
            checks++;
            if (valid_ID !== (i % 2 == 1) || PC_ID !== m_pc_id || inst_ID !== m_inst || PC !== m_pc) begin
                errors++;
                $display("FAIL two_cycle_ifid i=%0d got v=%b PC_ID=%h inst=%h PC=%h want v=%b %h %h %h",
                         i, valid_ID, PC_ID, inst_ID, PC, (i % 2 == 1), m_pc_id, m_inst, m_pc);
            end
        end
        checks++;
        if (stalls != 4) begin
            errors++; $display("FAIL two_cycle_stall_count got=%0d want=4", stalls);
        end
    endtask

    task automatic test_hold();
        logic [31:0] pc0, pcid0, inst0;
        lat_cfg = 0; lat = 0;
        pc0 = PC; pcid0 = PC_ID; inst0 = inst_ID;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (obs_req !== (i == 0) || PC !== pc0 || PC_ID !== pcid0 || inst_ID !== inst0) begin
                errors++;
                $display("FAIL hold_wait i=%0d got req=%b PC=%h PC_ID=%h inst=%h want %b %h %h %h",
                         i, obs_req, PC, PC_ID, inst_ID, (i == 0), pc0, pcid0, inst0);
            end
        end
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checks++;
        if ({PC, PC_ID, inst_ID, valid_ID} !== {pc0 + 32'd4, pc0, memword(pc0), 1'b1}) begin
            errors++;
            $display("FAIL hold_release got PC=%h PC_ID=%h inst=%h v=%b want %h %h %h 1",
                     PC, PC_ID, inst_ID, valid_ID, pc0 + 32'd4, pc0, memword(pc0));
        end
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (obs_addr !== pc0 + 32'd4 || PC_ID !== pc0 + 32'd4 || valid_ID !== 1'b1) begin
            errors++;
            $display("FAIL hold_resume got addr=%h PC_ID=%h v=%b want %h %h 1",
                     obs_addr, PC_ID, valid_ID, pc0 + 32'd4, pc0 + 32'd4);
        end
    endtask

    task automatic test_redirect_outstanding();
        logic [31:0] p;
        lat_cfg = 2; lat = 2;
        p = PC;
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
        checks++;
        if ({PC, inst_ID, valid_ID} !== {32'h100, NOP, 1'b0}) begin
            errors++;
            $display("FAIL redir_flush got PC=%h inst=%h v=%b want 100 %h 0", PC, inst_ID, valid_ID, NOP);
        end
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== p || imem_ack !== 1'b1) begin
            errors++;
            $display("FAIL redir_drop_addr got req=%b addr=%h ack=%b want 1 %h 1", obs_req, obs_addr, imem_ack, p);
        end
        checks++;
        if (valid_ID !== 1'b0 || inst_ID !== NOP || PC !== 32'h100) begin
            errors++;
            $display("FAIL redir_discard got v=%b inst=%h PC=%h want 0 %h 100", valid_ID, inst_ID, PC, NOP);
        end
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin
            errors++; $display("FAIL redir_new_addr got req=%b addr=%h want 1 00000100", obs_req, obs_addr);
        end
    endtask

    task automatic test_redirect_ack_same();
        lat_cfg = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
            checks++;
            if ({PC, PC_ID, inst_ID, valid_ID} !== {m_pc, m_pc_id, m_inst, m_valid}) begin
                errors++;
                $display("FAIL same_pre i=%0d got %h %h %h %b want %h %h %h %b",
                         i, PC, PC_ID, inst_ID, valid_ID, m_pc, m_pc_id, m_inst, m_valid);
            end
        end
        cycle(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
        checks++;
        if (imem_ack !== 1'b1 || {PC, inst_ID, valid_ID} !== {32'h200, NOP, 1'b0}) begin
            errors++;
            $display("FAIL same_redirect got ack=%b PC=%h inst=%h v=%b want 1 200 %h 0",
                     imem_ack, PC, inst_ID, valid_ID, NOP);
        end
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (obs_addr !== 32'h200 || PC_ID !== 32'h200 || inst_ID !== memword(32'h200) || valid_ID !== 1'b1) begin
            errors++;
            $display("FAIL same_next got addr=%h PC_ID=%h inst=%h v=%b want 200 200 %h 1",
                     obs_addr, PC_ID, inst_ID, valid_ID, memword(32'h200));
        end
    endtask

    task automatic test_load_use();
        logic [31:0] pc0, pcid0, inst0;
        int          seen;
        lat_cfg = 0;
        pc0 = PC; pcid0 = PC_ID; inst0 = inst_ID; seen = 0;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (PC !== pc0 || PC_ID !== pcid0 || inst_ID !== inst0) begin
                errors++;
                $display("FAIL load_use_hold i=%0d got %h %h %h want %h %h %h",
                         i, PC, PC_ID, inst_ID, pc0, pcid0, inst0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
            if (valid_ID && PC_ID == pc0) seen++;
            checks++;
            if (PC_ID !== pc0 + 32'(i * 4) || inst_ID !== memword(pc0 + 32'(i * 4)) || valid_ID !== 1'b1) begin
                errors++;
                $display("FAIL load_use_seq i=%0d got PC_ID=%h inst=%h v=%b want %h %h 1",
                         i, PC_ID, inst_ID, valid_ID, pc0 + 32'(i * 4), memword(pc0 + 32'(i * 4)));
            end
        end
        checks++;
        if (seen != 1) begin
            errors++; $display("FAIL load_use_once got=%0d want=1", seen);
        end
    endtask

    task automatic test_random();
        logic        redir, pw, iw, r, prev_stall;
        logic [31:0] tgt, prev_addr;
        lat_cfg = -1;
        prev_stall = 1'b0; prev_addr = '0;
        for (int i = 0; i < 400; i++) begin
            r     = (i == 200);
            redir = ($urandom_range(0, 11) == 0);
            tgt   = {16'h0, 16'($urandom)} & 32'hFFFF_FFFC;
            pw    = ($urandom_range(0, 4) != 0);
            iw    = ($urandom_range(0, 4) != 0);
            cycle(r, redir, tgt, pw, iw);
            checks++;
            if (obs_req !== exp_req || obs_stall !== exp_stall || (exp_req && obs_addr !== exp_addr)) begin
                errors++;
                $display("FAIL rand_hs i=%0d got req=%b stall=%b addr=%h want %b %b %h",
                         i, obs_req, obs_stall, obs_addr, exp_req, exp_stall, exp_addr);
            end
            checks++;
            if (prev_stall && !r && (obs_req !== 1'b1 || obs_addr !== prev_addr)) begin
                errors++;
                $display("FAIL rand_addr_stable i=%0d got req=%b addr=%h want 1 %h", i, obs_req, obs_addr, prev_addr);
            end
            prev_stall = obs_stall;
            prev_addr  = obs_addr;
            checks++;
            if ({PC, PC_ID, inst_ID, valid_ID} !== {m_pc, m_pc_id, m_inst, m_valid}) begin
                errors++;
                $display("FAIL rand_state i=%0d got PC=%h PC_ID=%h inst=%h v=%b want %h %h %h %b",
                         i, PC, PC_ID, inst_ID, valid_ID, m_pc, m_pc_id, m_inst, m_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; pc_write = 1'b0; ifid_write = 1'b0;
        npc = '0; imem_ack = 1'b0; imem_rdata = '0;
        m_pc = RST_PC; m_pc_id = '0; m_inst = NOP; m_valid = 1'b0;
        m_discard = 1'b0; m_drop = '0;
        test_reset();
        test_zero_wait();
        test_two_cycle();
        test_hold();
        test_redirect_outstanding();
        test_redirect_ack_same();
        test_load_use();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
